// File: rtl/change_dispenser.sv
// Change dispenser: pays out a latched change value one coin at a time, largest coin first,
// over a req/ack handshake with a coin hopper, with an ack timeout that raises a held fault.
module change_dispenser #(
    parameter int unsigned DEN3        = 50,
    parameter int unsigned DEN2        = 20,
    parameter int unsigned DEN1        = 10,
    parameter int unsigned DEN0        = 5,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] change_in,
    input  logic       coin_ack,
    input  logic       clear_fault,
    output logic       busy,
    output logic       coin_req,
    output logic [1:0] coin_sel,
    output logic [5:0] coin_count,
    output logic [7:0] residue,
    output logic       done,
    output logic       fault
);

    localparam logic [7:0] D3      = 8'(DEN3);
    localparam logic [7:0] D2      = 8'(DEN2);
    localparam logic [7:0] D1      = 8'(DEN1);
    localparam logic [7:0] D0      = 8'(DEN0);
    localparam logic [7:0] TIMEOUT = 8'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StReq,
        StGap,
        StDone,
        StFault
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] remaining_q, remaining_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] sel_q, sel_d;
    logic [5:0] count_q, count_d;
    logic [7:0] residue_q, residue_d;

    function automatic logic [7:0] den_of(input logic [1:0] sel);
        case (sel)
            2'd3:    den_of = D3;
            2'd2:    den_of = D2;
            2'd1:    den_of = D1;
            default: den_of = D0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            remaining_q <= 8'd0;
            timer_q     <= 8'd0;
            sel_q       <= 2'd0;
            count_q     <= 6'd0;
            residue_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            sel_q       <= sel_d;
            count_q     <= count_d;
            residue_q   <= residue_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        sel_d       = sel_q;
        count_d     = count_q;
        residue_d   = residue_q;
        case (state_q)
            StIdle: begin
                if (load) begin
                    remaining_d = change_in;
                    count_d     = 6'd0;
                    residue_d   = 8'd0;
                    state_d     = StSelect;
                end
            end
            StSelect: begin
                if (remaining_q == 8'd0) begin
                    state_d = StDone;
                end else if (remaining_q < D0) begin
                    residue_d = remaining_q;
                    state_d   = StDone;
                end else begin
                    // Greedy pick: only a coin no larger than remaining, so no underflow later.
                    if (remaining_q >= D3)      sel_d = 2'd3;
                    else if (remaining_q >= D2) sel_d = 2'd2;
                    else if (remaining_q >= D1) sel_d = 2'd1;
                    else                        sel_d = 2'd0;
                    timer_d = 8'd0;
                    state_d = StReq;
                end
            end
            StReq: begin
                timer_d = timer_q + 8'd1;
                // Ack takes priority over a coincident timeout.
                if (coin_ack) begin
                    remaining_d = remaining_q - den_of(sel_q);
                    if (count_q != 6'd63) count_d = count_q + 6'd1;
                    state_d = StGap;
                end else if (timer_q == TIMEOUT) begin
                    state_d = StFault;
                end
            end
            StGap:   state_d = StSelect;
            StDone:  state_d = StIdle;
            StFault: if (clear_fault) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy       = (state_q == StSelect) || (state_q == StReq) || (state_q == StGap);
    assign coin_req   = (state_q == StReq);
    assign done       = (state_q == StDone);
    assign fault      = (state_q == StFault);
    assign coin_sel   = sel_q;
    assign coin_count = count_q;
    assign residue    = residue_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy coin model feeds a queue of expected coin_sel
// values that is drained as the DUT raises coin_req.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] change_in;
    logic       coin_ack;
    logic       clear_fault;
    logic       busy;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic [5:0] coin_count;
    logic [7:0] residue;
    logic       done;
    logic       fault;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] sel_q[$];

    change_dispenser dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .change_in  (change_in),
        .coin_ack   (coin_ack),
        .clear_fault(clear_fault),
        .busy       (busy),
        .coin_req   (coin_req),
        .coin_sel   (coin_sel),
        .coin_count (coin_count),
        .residue    (residue),
        .done       (done),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Greedy reference: pushes expected coin_sel per coin, returns count and residue.
    task automatic model(input logic [7:0] amt, output logic [5:0] cnt, output logic [7:0] res);
        int rem;
        rem = int'(amt);
        cnt = 6'd0;
        while (rem >= 5) begin
            if (rem >= 50)      begin sel_q.push_back(2'd3); rem -= 50; end
            else if (rem >= 20) begin sel_q.push_back(2'd2); rem -= 20; end
            else if (rem >= 10) begin sel_q.push_back(2'd1); rem -= 10; end
            else                begin sel_q.push_back(2'd0); rem -= 5;  end
            cnt++;
        end
        res = 8'(rem);
    endtask

    task automatic pay(input logic [7:0] amt, input int delay, input int load_at,
                       output int done_cyc);
        logic [5:0] exp_cnt;
        logic [7:0] exp_res;
        int wait_cnt;
        int gap;
        bit seen;
        sel_q.delete();
        model(amt, exp_cnt, exp_res);
        change_in = amt;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("busy_after_load", 32'(busy), 32'd1);
        wait_cnt = 0;
        gap = 0;
        seen = 1'b0;
        done_cyc = -1;
        for (int cyc = 0; cyc < 500 && !seen; cyc++) begin
            if (gap > 0) begin
                chk("req_gap", 32'(coin_req), 32'd0);
                gap--;
            end else if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end else if (coin_req) begin
                if (sel_q.size() == 0) begin
                    chk("unexpected_req", 32'(coin_req), 32'd0);
                end else if (wait_cnt == delay) begin
                    chk("coin_sel", 32'(coin_sel), 32'(sel_q.pop_front()));
                    chk("busy_in_req", 32'(busy), 32'd1);
                    coin_ack = 1'b1;
                    wait_cnt = 0;
                    gap = 2;
                end else begin
                    wait_cnt++;
                end
            end
            if (cyc == load_at) begin
                load = 1'b1;
                change_in = 8'd20;
            end
            if (!seen) begin
                tick();
                coin_ack = 1'b0;
                load = 1'b0;
            end
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("coin_count", 32'(coin_count), 32'(exp_cnt));
        chk("residue", 32'(residue), 32'(exp_res));
        tick();
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        sel_q.delete();
    endtask

    initial begin
        int dc;
        int n;
        reset = 1'b1;
        load = 1'b0;
        change_in = 8'd0;
        coin_ack = 1'b0;
        clear_fault = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_coin_req", 32'(coin_req), 32'd0);
        chk("rst_coin_sel", 32'(coin_sel), 32'd0);
        chk("rst_coin_count", 32'(coin_count), 32'd0);
        chk("rst_residue", 32'(residue), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);

        // 85 -> 50,20,10,5, ack two cycles into each request.
        pay(8'd85, 2, -1, dc);

        // Zero change: done after two edges, no coin requests.
        pay(8'd0, 1, -1, dc);
        chk("zero_done_latency", 32'(dc), 32'd1);

        // 33 -> 20,10 with residue 3, prompt acks.
        pay(8'd33, 0, -1, dc);

        // Hopper never answers: 16 request cycles then fault.
        change_in = 8'd40;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        n = 0;
        while (coin_req && n < 40) begin
            n++;
            tick();
        end
        chk("req_high_cycles", 32'(n), 32'd16);
        chk("fault_set", 32'(fault), 32'd1);
        chk("fault_req_low", 32'(coin_req), 32'd0);
        chk("fault_busy_low", 32'(busy), 32'd0);
        chk("fault_sel_held", 32'(coin_sel), 32'd2);
        change_in = 8'd10;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk("fault_ignores_load", 32'(fault), 32'd1);
        chk("fault_ignores_load_busy", 32'(busy), 32'd0);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("fault_cleared", 32'(fault), 32'd0);
        chk("cleared_idle", 32'(busy), 32'd0);
        pay(8'd10, 1, -1, dc);

        // 255 -> 5x50 + 5; a load of 20 mid-payout must be ignored.
        pay(8'd255, 1, 3, dc);

        // Reset during the second request of a 70 payout.
        change_in = 8'd70;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk("r6_first_req", 32'(coin_req), 32'd1);
        chk("r6_first_sel", 32'(coin_sel), 32'd3);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        tick();
        tick();
        chk("r6_second_req", 32'(coin_req), 32'd1);
        chk("r6_second_sel", 32'(coin_sel), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r6_busy", 32'(busy), 32'd0);
        chk("r6_coin_req", 32'(coin_req), 32'd0);
        chk("r6_coin_sel", 32'(coin_sel), 32'd0);
        chk("r6_coin_count", 32'(coin_count), 32'd0);
        chk("r6_residue", 32'(residue), 32'd0);
        chk("r6_done", 32'(done), 32'd0);
        chk("r6_fault", 32'(fault), 32'd0);
        coin_ack = 1'b1;
        tick();
        tick();
        tick();
        coin_ack = 1'b0;
        chk("r6_late_ack_count", 32'(coin_count), 32'd0);
        chk("r6_late_ack_req", 32'(coin_req), 32'd0);
        chk("r6_late_ack_busy", 32'(busy), 32'd0);
        pay(8'd60, 1, -1, dc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
